wb_port_arbiter: RTL

Round-robin arbiter and one-entry output buffer that shares a single 32-bit write-back path among three requesters: ALU result, load data and multiplier result. It generates the 2-bit select for the team's 3-input 32-bit mux on that path. It captures the selected operand into an output register and completes a valid/ready-style handshake on both sides. It sits between the execute-stage result sources and the register-file write port.

---
 rtl/wb_port_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one write-back path among ALU, load and multiplier results,
// with a one-entry output register; ack is combinational, captured data appears one cycle later.
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [2:0]            ack,
  output logic [1:0]            mux_sel,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready
);

  logic [1:0]            last;
  logic [1:0]            winner;
  logic                  free;
  logic                  grant;
  logic [DATA_WIDTH-1:0] sel_data;

  assign free = !out_valid || out_ready;

  // Priority starts just after the last winner and wraps; last is never 2'b11.
  always_comb begin
    winner = 2'd0;
    case (last)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Gating with rst_n keeps ack low for the whole reset window, not just after an edge.
  assign grant   = rst_n && free && (req != 3'b000);
  assign ack     = grant ? (3'b001 << winner) : 3'b000;
  assign mux_sel = grant ? winner : out_src;

  always_comb begin
    sel_data = in0;
    case (mux_sel)
      2'd1:    sel_data = in1;
      2'd2:    sel_data = in2;
      default: sel_data = in0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      last      <= 2'd2;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= winner;
      last      <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
